// File: rtl/mem_if_pkg.sv
// Shared types and constants for the cache fill engine and its memory port.
package mem_if_pkg;

  localparam int unsigned ADDR_WIDTH      = 16;
  localparam int unsigned DATA_WIDTH      = 16;
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned OFFSET_BITS     = 4;
  localparam int unsigned WORD_IDX_BITS   = 3;
  localparam int unsigned CNT_WIDTH       = 4;
  localparam int unsigned BASE_WIDTH      = ADDR_WIDTH - OFFSET_BITS;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StFill
  } fill_state_e;

  // Byte address of word idx inside the block at base.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(logic [BASE_WIDTH-1:0]    base,
                                                      logic [WORD_IDX_BITS-1:0] idx);
    return {base, idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Request, cache-array and memory-port signals of the cache fill engine.
interface cache_fill_fsm_if;
  import mem_if_pkg::*;

  logic                     miss_req;
  logic [ADDR_WIDTH-1:0]    miss_addr;
  logic                     wr_req;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     busy;
  logic                     fill_done;
  logic                     wr_done;
  logic                     cache_we;
  logic [WORD_IDX_BITS-1:0] cache_word;
  logic [DATA_WIDTH-1:0]    cache_data;
  logic                     tag_we;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0]    mem_data_in;
  logic                     mem_enable;
  logic                     mem_wr;
  logic [DATA_WIDTH-1:0]    mem_data_out;
  logic                     mem_data_valid;

  modport master (
    input  miss_req, miss_addr, wr_req, wr_addr, wr_data, mem_data_out, mem_data_valid,
    output busy, fill_done, wr_done, cache_we, cache_word, cache_data, tag_we,
    output mem_addr, mem_data_in, mem_enable, mem_wr
  );

  modport slave (
    output miss_req, miss_addr, wr_req, wr_addr, wr_data, mem_data_out, mem_data_valid,
    input  busy, fill_done, wr_done, cache_we, cache_word, cache_data, tag_we,
    input  mem_addr, mem_data_in, mem_enable, mem_wr
  );

endinterface

// File: rtl/cache_fill_fsm.sv
// Memory-port initiator: single-word write-through, and 8-word block fill into the cache array.
module cache_fill_fsm
  import mem_if_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master bus_io
);

  localparam cnt_t BlockWords = cnt_t'(WORDS_PER_BLOCK);
  localparam cnt_t LastWord   = cnt_t'(WORDS_PER_BLOCK - 1);

  fill_state_e           state_q, state_d;
  cnt_t                  issue_cnt_q, issue_cnt_d;
  cnt_t                  rcv_cnt_q, rcv_cnt_d;
  logic [BASE_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-2:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  fill_last;

  // Offset bits of the miss address and bit 0 of the write address are never needed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_io.miss_addr[OFFSET_BITS-1:0], bus_io.wr_addr[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
      base_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      base_q      <= base_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Memory-side issue. Depends only on registered state so the read valid may be
  // returned combinationally by a zero-latency memory without forming a loop.
  always_comb begin
    issue_cnt_d        = issue_cnt_q;
    bus_io.mem_enable  = 1'b0;
    bus_io.mem_wr      = 1'b0;
    bus_io.mem_addr    = '0;
    bus_io.mem_data_in = '0;
    bus_io.wr_done     = 1'b0;
    unique case (state_q)
      StIdle: issue_cnt_d = '0;
      StWrite: begin
        bus_io.mem_enable  = 1'b1;
        bus_io.mem_wr      = 1'b1;
        bus_io.mem_addr    = {wr_addr_q, 1'b0};
        bus_io.mem_data_in = wr_data_q;
        bus_io.wr_done     = 1'b1;
      end
      StFill: begin
        if (issue_cnt_q < BlockWords) begin
          bus_io.mem_enable = 1'b1;
          bus_io.mem_addr   = word_addr(base_q, issue_cnt_q[WORD_IDX_BITS-1:0]);
          issue_cnt_d       = issue_cnt_q + cnt_t'(1);
        end
      end
      default: ;
    endcase
  end

  // Read return. The read issued this cycle counts as outstanding (issue_cnt_d),
  // which lets a zero-latency memory complete a word in its issue cycle.
  always_comb begin
    rcv_cnt_d         = rcv_cnt_q;
    bus_io.cache_we   = 1'b0;
    bus_io.cache_word = '0;
    bus_io.cache_data = '0;
    bus_io.tag_we     = 1'b0;
    bus_io.fill_done  = 1'b0;
    fill_last         = 1'b0;
    if (state_q == StIdle) begin
      rcv_cnt_d = '0;
    end else if (state_q == StFill && bus_io.mem_data_valid && rcv_cnt_q < issue_cnt_d) begin
      bus_io.cache_we   = 1'b1;
      bus_io.cache_word = rcv_cnt_q[WORD_IDX_BITS-1:0];
      bus_io.cache_data = bus_io.mem_data_out;
      rcv_cnt_d         = rcv_cnt_q + cnt_t'(1);
      if (rcv_cnt_q == LastWord) begin
        fill_last        = 1'b1;
        bus_io.tag_we    = 1'b1;
        bus_io.fill_done = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.wr_req) begin
          state_d   = StWrite;
          wr_addr_d = bus_io.wr_addr[ADDR_WIDTH-1:1];
          wr_data_d = bus_io.wr_data;
        end else if (bus_io.miss_req) begin
          state_d = StFill;
          base_d  = bus_io.miss_addr[ADDR_WIDTH-1:OFFSET_BITS];
        end
      end
      StWrite: state_d = StIdle;
      StFill: begin
        if (fill_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus_io.busy = (state_q != StIdle);

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm against a latency-configurable memory model.
module tb_cache_fill_fsm;
  import mem_if_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_fsm_if bus ();

  cache_fill_fsm dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; int cyc; } mem_exp_t;
  typedef struct { logic [2:0] word; logic [15:0] data; bit last; int cyc; } cache_exp_t;
  typedef struct { logic [15:0] data; int due; } rd_t;

  mem_exp_t   exp_mem[$];
  cache_exp_t exp_cache[$];
  rd_t        rq[$];

  logic [15:0] mem [0:32767];
  bit          mem_inited = 0;
  int          cyc = 0;
  int          lat = 0;
  int          drop_a = -1;
  int          drop_b = -1;
  int          n_chk = 0;
  int          n_fail = 0;
  int          t0;
  logic        valid_lat = 1'b0;
  logic [15:0] data_lat = '0;
  logic        force_valid = 1'b0;
  logic [15:0] ed [8];

  // Snapshot of memory-port requests, taken mid-cycle.
  logic        cap_en, cap_wr, cap_valid;
  logic [15:0] cap_addr, cap_din;

  assign bus.mem_data_valid = force_valid |
                              ((lat == 0) ? (bus.mem_enable & ~bus.mem_wr) : valid_lat);
  assign bus.mem_data_out   = force_valid ? 16'hDEAD :
                              (lat == 0) ? mem[bus.mem_addr[15:1]] : data_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return {6'b0, bus.busy, bus.fill_done, bus.wr_done, bus.cache_we, bus.cache_word,
            bus.cache_data, bus.tag_we, bus.mem_addr, bus.mem_data_in, bus.mem_enable,
            bus.mem_wr};
  endfunction

  always @(negedge clk) begin
    cap_en    = bus.mem_enable;
    cap_wr    = bus.mem_wr;
    cap_addr  = bus.mem_addr;
    cap_din   = bus.mem_data_in;
    cap_valid = valid_lat;
  end

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 32768; i++) mem[i] = 16'(i) ^ 16'h5A5A;
      for (int i = 0; i < 8; i++) begin
        mem[15'h2050 + 15'(i)] = 16'h0100 + 16'(i);
        mem[15'h3F98 + 15'(i)] = 16'hC3C0 + 16'(i);
      end
      mem_inited = 1;
    end
    if (cap_valid && rq.size() != 0) void'(rq.pop_front());
    if (cap_en && !cap_wr && lat != 0) rq.push_back('{mem[cap_addr[15:1]], cyc + lat});
    if (cap_en && cap_wr) mem[cap_addr[15:1]] = cap_din;
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    valid_lat = (rq.size() != 0) && (rq[0].due <= cyc) && (cyc != drop_a) && (cyc != drop_b);
    data_lat  = valid_lat ? rq[0].data : 16'h0;
  end

  // Monitor: every memory access and cache write must match the head of its queue.
  always @(negedge clk) begin
    mem_exp_t   m;
    cache_exp_t c;
    if (rst) begin
      check("outputs_in_reset", outs(), 64'h0);
    end else begin
      if (bus.mem_enable) begin
        if (exp_mem.size() == 0) begin
          check("unexpected_mem_access", {bus.mem_wr, bus.mem_addr}, 64'h0);
        end else begin
          m = exp_mem.pop_front();
          check("mem_wr", bus.mem_wr, m.wr);
          check("mem_addr", bus.mem_addr, m.addr);
          check("wr_done", bus.wr_done, m.wr);
          if (m.wr) check("mem_data_in", bus.mem_data_in, m.data);
          if (m.cyc >= 0) check("mem_cycle", cyc, m.cyc);
        end
      end else if (bus.wr_done) begin
        check("wr_done_without_access", bus.wr_done, 64'h0);
      end
      if (bus.cache_we) begin
        if (exp_cache.size() == 0) begin
          check("unexpected_cache_we", {bus.cache_word, bus.cache_data}, 64'h0);
        end else begin
          c = exp_cache.pop_front();
          check("cache_word", bus.cache_word, c.word);
          check("cache_data", bus.cache_data, c.data);
          check("tag_we_fill_done", {bus.tag_we, bus.fill_done}, {c.last, c.last});
          if (c.cyc >= 0) check("cache_cycle", cyc, c.cyc);
        end
      end else if (bus.tag_we || bus.fill_done) begin
        check("done_without_cache_we", {bus.tag_we, bus.fill_done}, 64'h0);
      end
    end
  end

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle after the done pulse, where the requester drops its request.
  task automatic wait_done(input bit fill, input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = fill ? bus.fill_done : bus.wr_done;
    end
    if (!seen) check(fill ? "fill_done_timeout" : "wr_done_timeout", 0, 1);
    wait_edge();
  endtask

  task automatic push_fill(input logic [15:0] base, input int first, input bit timed,
                           input int last_cyc);
    for (int i = 0; i < 8; i++) begin
      exp_mem.push_back('{1'b0, base + 16'(2 * i), 16'h0, first + i});
      exp_cache.push_back('{3'(i), ed[i], i == 7,
                            timed ? first + i : ((i == 7) ? last_cyc : -1)});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && rq.size() != 0; i++) wait_edge();
    check("read_queue_drained", rq.size(), 0);
  endtask

  initial begin
    bus.miss_req  = 1'b0;
    bus.miss_addr = '0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    repeat (3) wait_edge();
    rst = 1'b0;
    @(negedge clk);
    check("outputs_after_reset", outs(), 64'h0);
    wait_edge();

    // Single write-through.
    t0 = cyc;
    exp_mem.push_back('{1'b1, 16'h1236, 16'hBEEF, t0 + 1});
    bus.wr_addr = 16'h1236;
    bus.wr_data = 16'hBEEF;
    bus.wr_req  = 1'b1;
    wait_done(0, 10);
    bus.wr_req = 1'b0;
    check("idle_after_write", bus.busy, 0);
    wait_edge();

    // Zero-latency fill.
    for (int i = 0; i < 8; i++) ed[i] = 16'h0100 + 16'(i);
    t0 = cyc;
    push_fill(16'h40A0, t0 + 1, 1, t0 + 8);
    bus.miss_addr = 16'h40A6;
    bus.miss_req  = 1'b1;
    wait_done(1, 40);
    bus.miss_req = 1'b0;
    check("idle_after_fill", bus.busy, 0);
    wait_edge();

    // Latency-3 fill with two dropped valid cycles: last word lands in cycle 8+3+2.
    lat = 3;
    for (int i = 0; i < 8; i++) ed[i] = 16'hC3C0 + 16'(i);
    t0 = cyc;
    drop_a = t0 + int'($urandom_range(4, 7));
    drop_b = drop_a + int'($urandom_range(1, 3));
    push_fill(16'h7F30, t0 + 1, 0, t0 + 13);
    bus.miss_addr = 16'h7F3E;
    bus.miss_req  = 1'b1;
    wait_done(1, 60);
    bus.miss_req = 1'b0;
    drain();
    drop_a = -1;
    drop_b = -1;
    lat = 0;
    wait_edge();

    // Simultaneous write and miss: write first, fill from cycle 3 sees both writes.
    ed = '{16'h5342, 16'h5343, 16'h5340, 16'hBEEF, 16'h5346, 16'h1234, 16'h5344, 16'h5345};
    t0 = cyc;
    exp_mem.push_back('{1'b1, 16'h123A, 16'h1234, t0 + 1});
    push_fill(16'h1230, t0 + 3, 1, t0 + 10);
    bus.wr_addr   = 16'h123A;
    bus.wr_data   = 16'h1234;
    bus.wr_req    = 1'b1;
    bus.miss_addr = 16'h1231;
    bus.miss_req  = 1'b1;
    wait_done(0, 10);
    bus.wr_req = 1'b0;
    wait_done(1, 40);
    bus.miss_req = 1'b0;
    wait_edge();

    // Reset in fill cycle 4 with latency 2: only word 0 has landed, two valids arrive late.
    lat = 2;
    t0 = cyc;
    for (int i = 0; i < 3; i++) exp_mem.push_back('{1'b0, 16'h40A0 + 16'(2 * i), 16'h0, t0 + 1 + i});
    exp_cache.push_back('{3'd0, 16'h0100, 1'b0, t0 + 3});
    bus.miss_addr = 16'h40A6;
    bus.miss_req  = 1'b1;
    while (cyc < t0 + 4) wait_edge();
    rst = 1'b1;
    #1;
    check("outputs_on_async_reset", outs(), 64'h0);
    bus.miss_req = 1'b0;
    wait_edge();
    rst = 1'b0;
    @(negedge clk);
    check("late_valid_ignored", {bus.busy, bus.cache_we, bus.fill_done}, 64'h0);
    drain();
    lat = 0;
    wait_edge();

    // A fresh miss after the aborted one completes normally.
    for (int i = 0; i < 8; i++) ed[i] = 16'h0100 + 16'(i);
    t0 = cyc;
    push_fill(16'h40A0, t0 + 1, 1, t0 + 8);
    bus.miss_addr = 16'h40A6;
    bus.miss_req  = 1'b1;
    wait_done(1, 40);
    bus.miss_req = 1'b0;
    wait_edge();

    // Spurious valid while idle.
    force_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("spurious_valid_idle", {bus.busy, bus.cache_we, bus.tag_we}, 64'h0);
    end
    wait_edge();
    force_valid = 1'b0;
    repeat (2) wait_edge();

    check("mem_queue_empty", exp_mem.size(), 0);
    check("cache_queue_empty", exp_cache.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Initiator side of the 16-bit word memory port: turns cache miss and write-through requests into memory read/write transactions. On a miss it fetches one 8-word (16-byte) block from memory and streams the words into the cache data array, then writes the tag. On a write it issues a single memory write. It sits between the cache controller and the memory model, and owns every memory-side control signal.

## Interface
- ADDR_WIDTH, 16, byte address width; bit 0 is always driven 0
- WORDS_PER_BLOCK, 8, words per cache block; power of two
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- miss_req  in  1  level; fill request, sampled only in IDLE
- miss_addr  in  ADDR_WIDTH  missing address; block base = miss_addr[15:4]
- wr_req  in  1  level; write-through request, sampled only in IDLE
- wr_addr  in  ADDR_WIDTH  write byte address
- wr_data  in  16  write data
- busy  out  1  state != IDLE
- fill_done  out  1  one-cycle pulse with the last fill word
- wr_done  out  1  one-cycle pulse in the WRITE cycle
- cache_we  out  1  write cache_data into word cache_word of the block
- cache_word  out  3  word index within block
- cache_data  out  16  fill data
- tag_we  out  1  write tag/valid; coincides with fill_done
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_data_in  out  16  memory write data
- mem_enable  out  1  memory access enable
- mem_wr  out  1  1 = write, 0 = read
- mem_data_out  in  16  memory read data
- mem_data_valid  in  1  mem_data_out holds the next in-order read word

## Operation
- States: IDLE, WRITE, FILL.
- IDLE: wr_req=1 -> WRITE (latch wr_addr, wr_data); else miss_req=1 -> FILL (latch miss_addr[15:4], clear issue_cnt and rcv_cnt); else stay. Write has priority when both are asserted. The fill follows on the next IDLE cycle if miss_req is still high.
- WRITE: mem_enable=1, mem_wr=1, mem_addr = latched address with bit 0 = 0, mem_data_in = latched data, wr_done=1. Next state is IDLE. Lasts exactly one cycle.
- FILL issue: while issue_cnt < 8, drive mem_enable=1, mem_wr=0, mem_addr = {base, issue_cnt[2:0], 1'b0}, then increment issue_cnt. One read is issued per cycle, back-to-back, with no stall input.
- FILL receive: when mem_data_valid=1 and rcv_cnt < issue_cnt, drive cache_we=1, cache_word=rcv_cnt, cache_data=mem_data_out, then increment rcv_cnt.
- A valid with rcv_cnt >= issue_cnt is ignored, and so is any valid outside FILL.
- When the received word has rcv_cnt=7: tag_we=1 and fill_done=1, next state is IDLE.
- Reads and writes are never issued in the same cycle; WRITE and FILL are mutually exclusive.
- issue_cnt and rcv_cnt are 4-bit (0..8) and do not wrap; issue stops at 8.
- Requester contract: deassert miss_req on the edge after fill_done and wr_req on the edge after wr_done. A request still high in the next IDLE cycle starts a new transaction.

## Timing
- Reset: state=IDLE, counters=0, latches=0. Every output is 0 during and after reset until a request is accepted.
- Outputs are combinational from state, counters and latches. Control outputs (mem_enable, mem_wr, cache_we, tag_we, fill_done, wr_done) never depend combinationally on miss_req or wr_req.
- Request sampled at edge 0 -> first memory access in cycle 1.
- Write: wr_done in cycle 1, IDLE in cycle 2.
- Fill, zero-latency memory (valid = mem_enable & ~mem_wr): reads and cache writes in cycles 1-8, fill_done in cycle 8.
- Fill, N-cycle memory: issues in cycles 1-8, fill_done in cycle 8+N. Any latency and any gaps in mem_data_valid are tolerated.
- rst mid-WRITE or mid-FILL: immediate return to IDLE, the transaction is aborted, no done pulse, and late valids are ignored.

## Structure
- Shared package mem_if_pkg holds:
  - state enum {IDLE, WRITE, FILL}
  - WORDS_PER_BLOCK = 8, OFFSET_BITS = 4, WORD_IDX_BITS = 3
  - counter width 4
- Single module; no sub-module. The counters are small enough to stay inline.

## Test plan
- Write: wr_req with wr_addr=0x1236, wr_data=0xBEEF -> one cycle with mem_enable=1, mem_wr=1, mem_addr=0x1236, mem_data_in=0xBEEF, wr_done=1; a following read of 0x1236 returns 0xBEEF.
- Zero-latency fill: miss_req, miss_addr=0x40A6, memory preloaded with 0x0100+i at 0x40A0+2i -> mem_addr 0x40A0..0x40AE in cycles 1-8; cache_we with words 0..7 and data 0x0100..0x0107; tag_we and fill_done in cycle 8.
- Latency-3 fill with valid gaps (valid dropped in 2 random cycles) -> exactly 8 in-order cache writes; fill_done on the 8th valid; no spurious valid is counted.
- Simultaneous wr_req and miss_req -> WRITE first (wr_done in cycle 1), then FILL starts in cycle 3; no cycle has mem_enable with mixed read and write.
- rst asserted at FILL cycle 4 -> all outputs 0 immediately; 2 late valids are ignored; a new miss completes cleanly.
- Spurious mem_data_valid while IDLE -> no cache_we, no state change.
